// File: rtl/jpeg_axil_pkg.sv
// Shared constants for the JPEG AXI-Lite bridge: CSR offsets, response codes, bit indices.
// The PERF register decodes only when JPEG_BRIDGE_PERF_CNT_EN is defined.
package jpeg_axil_pkg;

   localparam logic [31:0] OFF_CTRL   = 32'h00;
   localparam logic [31:0] OFF_STATUS = 32'h04;
   localparam logic [31:0] OFF_PIX    = 32'h08;
   localparam logic [31:0] OFF_RESULT = 32'h0C;
   localparam logic [31:0] OFF_IRQ    = 32'h10;
   localparam logic [31:0] OFF_PERF   = 32'h14;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int CTRL_START   = 0;
   localparam int CTRL_IRQ_EN  = 1;
   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_RESV    = 2;
   localparam int STAT_LVL_LSB = 8;

   typedef enum logic [2:0] {
      REG_CTRL, REG_STATUS, REG_PIX, REG_RESULT, REG_IRQ, REG_PERF, REG_NONE
   } regSel_e;

   function automatic regSel_e decodeAddr(input logic [31:0] addr);
      regSel_e sel;
      case (addr & 32'hFFFF_FFFC)
         OFF_CTRL:   sel = REG_CTRL;
         OFF_STATUS: sel = REG_STATUS;
         OFF_PIX:    sel = REG_PIX;
         OFF_RESULT: sel = REG_RESULT;
         OFF_IRQ:    sel = REG_IRQ;
`ifdef JPEG_BRIDGE_PERF_CNT_EN
         OFF_PERF:   sel = REG_PERF;
`endif
         default:    sel = REG_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/jpeg_pix_fifo.sv
// Synchronous pixel FIFO with occupancy level; pushes into a full FIFO are dropped.
module jpeg_pix_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LW-1:0]    level_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wrPtr_q, rdPtr_q;
   logic [LW-1:0]    count_q;
   logic             doPush, doPop;

   assign full_o  = (count_q == LW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign level_o = count_q;
   assign doPush  = push_i && !full_o;
   assign doPop   = pop_i && !empty_o;
   assign data_o  = empty_o ? '0 : mem_q[rdPtr_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
         if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
         if (doPush && !doPop)      count_q <= count_q + 1'b1;
         else if (doPop && !doPush) count_q <= count_q - 1'b1;
      end
   end

   // Storage carries no reset; empty_o masks stale contents on the output.
   always_ff @(posedge clk_i) begin
      if (doPush) mem_q[wrPtr_q] <= data_i;
   end

endmodule

// File: rtl/jpeg_axil_stream_bridge.sv
// AXI4-Lite CSR front-end for the JPEG core: pixel FIFO push, result pop, busy/done and IRQ.
// Define JPEG_BRIDGE_PERF_CNT_EN to add the PERF busy-cycle counter at 0x14.
module jpeg_axil_stream_bridge
   import jpeg_axil_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 8,
   parameter int PIX_FIFO_DEPTH = 16
) (
   input  logic                      s00_axi_aclk,
   input  logic                      s00_axi_aresetn,
   input  logic [ADDR_WIDTH-1:0]     s00_axi_awaddr,
   input  logic                      s00_axi_awvalid,
   output logic                      s00_axi_awready,
   input  logic [DATA_WIDTH-1:0]     s00_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]   s00_axi_wstrb,
   input  logic                      s00_axi_wvalid,
   output logic                      s00_axi_wready,
   output logic [1:0]                s00_axi_bresp,
   output logic                      s00_axi_bvalid,
   input  logic                      s00_axi_bready,
   input  logic [ADDR_WIDTH-1:0]     s00_axi_araddr,
   input  logic                      s00_axi_arvalid,
   output logic                      s00_axi_arready,
   output logic [DATA_WIDTH-1:0]     s00_axi_rdata,
   output logic [1:0]                s00_axi_rresp,
   output logic                      s00_axi_rvalid,
   input  logic                      s00_axi_rready,
   output logic [DATA_WIDTH-1:0]     pix_tdata,
   output logic                      pix_tvalid,
   input  logic                      pix_tready,
   input  logic [DATA_WIDTH-1:0]     res_tdata,
   input  logic                      res_tvalid,
   output logic                      res_tready,
   output logic                      core_start,
   input  logic                      core_done,
   output logic                      jpeg_irq
);

   localparam int SW = DATA_WIDTH / 8;
   localparam int LW = $clog2(PIX_FIFO_DEPTH) + 1;

   logic                  awHeld_q, awHeld_d, wHeld_q, wHeld_d;
   logic [ADDR_WIDTH-1:0] awAddr_q, awAddr_d;
   logic [DATA_WIDTH-1:0] wData_q, wData_d;
   logic [SW-1:0]         wStrb_q, wStrb_d;
   logic                  awReady_q, awReady_d, wReady_q, wReady_d, arReady_q, arReady_d;
   logic                  bValid_q, bValid_d, rValid_q, rValid_d;
   logic [1:0]            bResp_q, bResp_d, rResp_q, rResp_d;
   logic [DATA_WIDTH-1:0] rData_q, rData_d;
   logic                  resReady_q, resReady_d, start_q, start_d;
   logic                  busy_q, busy_d, done_q, done_d;
   logic                  irqEn_q, irqEn_d, irqStat_q, irqStat_d, irq_q, irq_d;
`ifdef JPEG_BRIDGE_PERF_CNT_EN
   logic [31:0]           perf_q, perf_d;
`endif

   regSel_e          wrSel, rdSel;
   logic             strbFull, pixPush, wrExec, fifoFull, fifoEmpty;
   logic [LW-1:0]    fifoLevel;

   assign wrSel    = decodeAddr(32'(awAddr_q));
   assign rdSel    = decodeAddr(32'(s00_axi_araddr));
   assign strbFull = &wStrb_q;
   assign pixPush  = (wrSel == REG_PIX) && strbFull;
   // A full-strobe PIX_DATA write waits for FIFO space rather than being dropped.
   assign wrExec   = awHeld_q && wHeld_q && !(pixPush && fifoFull);

   jpeg_pix_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(PIX_FIFO_DEPTH)) uFifo (
      .clk_i   (s00_axi_aclk),
      .rst_ni  (s00_axi_aresetn),
      .push_i  (wrExec && pixPush),
      .data_i  (wData_q),
      .pop_i   (pix_tvalid && pix_tready),
      .data_o  (pix_tdata),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty),
      .level_o (fifoLevel)
   );

   always_comb begin
      awHeld_d   = awHeld_q;
      awAddr_d   = awAddr_q;
      wHeld_d    = wHeld_q;
      wData_d    = wData_q;
      wStrb_d    = wStrb_q;
      bValid_d   = bValid_q;
      bResp_d    = bResp_q;
      rValid_d   = rValid_q;
      rResp_d    = rResp_q;
      rData_d    = rData_q;
      resReady_d = 1'b0;
      start_d    = 1'b0;
      busy_d     = busy_q;
      done_d     = done_q;
      irqEn_d    = irqEn_q;
      irqStat_d  = irqStat_q;
      irq_d      = irqEn_q & irqStat_q;
`ifdef JPEG_BRIDGE_PERF_CNT_EN
      perf_d     = perf_q;
`endif

      if (s00_axi_awvalid && awReady_q) begin
         awHeld_d = 1'b1;
         awAddr_d = s00_axi_awaddr;
      end
      if (s00_axi_wvalid && wReady_q) begin
         wHeld_d = 1'b1;
         wData_d = s00_axi_wdata;
         wStrb_d = s00_axi_wstrb;
      end
      if (bValid_q && s00_axi_bready) bValid_d = 1'b0;

      if (wrExec) begin
         awHeld_d = 1'b0;
         wHeld_d  = 1'b0;
         bValid_d = 1'b1;
         bResp_d  = RESP_OKAY;
         case (wrSel)
            REG_CTRL: if (wStrb_q[0]) begin
               irqEn_d = wData_q[CTRL_IRQ_EN];
               start_d = wData_q[CTRL_START] && !busy_q;
            end
            REG_PIX: if (!strbFull) bResp_d = RESP_SLVERR;
            REG_IRQ: if (wStrb_q[0] && wData_q[0]) irqStat_d = 1'b0;
            default: bResp_d = RESP_SLVERR;
         endcase
      end

      if (start_d) begin
         busy_d = 1'b1;
         done_d = 1'b0;
      end
      // Completion comes last so it wins over a simultaneous W1C.
      if (core_done) begin
         busy_d    = 1'b0;
         done_d    = 1'b1;
         irqStat_d = 1'b1;
      end
`ifdef JPEG_BRIDGE_PERF_CNT_EN
      if (start_d) perf_d = '0;
      else if (busy_q && perf_q != '1) perf_d = perf_q + 1'b1;
`endif

      if (rValid_q && s00_axi_rready) rValid_d = 1'b0;
      if (s00_axi_arvalid && arReady_q) begin
         rValid_d = 1'b1;
         rResp_d  = RESP_OKAY;
         rData_d  = '0;
         case (rdSel)
            REG_CTRL:   rData_d[CTRL_IRQ_EN] = irqEn_q;
            REG_STATUS: begin
               rData_d[STAT_BUSY]            = busy_q;
               rData_d[STAT_DONE]            = done_q;
               rData_d[STAT_RESV]            = res_tvalid;
               rData_d[STAT_LVL_LSB +: LW]   = fifoLevel;
            end
            REG_RESULT: if (res_tvalid) begin
               rData_d    = res_tdata;
               resReady_d = 1'b1;
            end else begin
               rResp_d    = RESP_SLVERR;
            end
            REG_IRQ:    rData_d[0] = irqStat_q;
`ifdef JPEG_BRIDGE_PERF_CNT_EN
            REG_PERF:   rData_d = DATA_WIDTH'(perf_q);
`endif
            default:    rResp_d = RESP_SLVERR;
         endcase
      end

      awReady_d = !awHeld_d && !bValid_d;
      wReady_d  = !wHeld_d && !bValid_d;
      arReady_d = !rValid_d;
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         awHeld_q   <= 1'b0;
         awAddr_q   <= '0;
         wHeld_q    <= 1'b0;
         wData_q    <= '0;
         wStrb_q    <= '0;
         awReady_q  <= 1'b0;
         wReady_q   <= 1'b0;
         arReady_q  <= 1'b0;
         bValid_q   <= 1'b0;
         bResp_q    <= RESP_OKAY;
         rValid_q   <= 1'b0;
         rResp_q    <= RESP_OKAY;
         rData_q    <= '0;
         resReady_q <= 1'b0;
         start_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         irqEn_q    <= 1'b0;
         irqStat_q  <= 1'b0;
         irq_q      <= 1'b0;
`ifdef JPEG_BRIDGE_PERF_CNT_EN
         perf_q     <= '0;
`endif
      end else begin
         awHeld_q   <= awHeld_d;
         awAddr_q   <= awAddr_d;
         wHeld_q    <= wHeld_d;
         wData_q    <= wData_d;
         wStrb_q    <= wStrb_d;
         awReady_q  <= awReady_d;
         wReady_q   <= wReady_d;
         arReady_q  <= arReady_d;
         bValid_q   <= bValid_d;
         bResp_q    <= bResp_d;
         rValid_q   <= rValid_d;
         rResp_q    <= rResp_d;
         rData_q    <= rData_d;
         resReady_q <= resReady_d;
         start_q    <= start_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         irqEn_q    <= irqEn_d;
         irqStat_q  <= irqStat_d;
         irq_q      <= irq_d;
`ifdef JPEG_BRIDGE_PERF_CNT_EN
         perf_q     <= perf_d;
`endif
      end
   end

   assign s00_axi_awready = awReady_q;
   assign s00_axi_wready  = wReady_q;
   assign s00_axi_arready = arReady_q;
   assign s00_axi_bvalid  = bValid_q;
   assign s00_axi_bresp   = bResp_q;
   assign s00_axi_rvalid  = rValid_q;
   assign s00_axi_rresp   = rResp_q;
   assign s00_axi_rdata   = rData_q;
   assign pix_tvalid      = !fifoEmpty;
   assign res_tready      = resReady_q;
   assign core_start      = start_q;
   assign jpeg_irq        = irq_q;

endmodule

// File: tb/tb_jpeg_axil_stream_bridge.sv
// Self-checking bench for jpeg_axil_stream_bridge: CSR vector table, FIFO backpressure,
// result pops, IRQ set/clear races and mid-transaction reset.
module tb_jpeg_axil_stream_bridge;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  awaddr = '0, araddr = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
   logic        bready = 1'b1, rready = 1'b1;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata, pix_tdata, res_tdata = '0;
   logic        pix_tvalid, pix_tready = 1'b0, res_tvalid = 1'b0, res_tready;
   logic        core_start, core_done = 1'b0, jpeg_irq;

`ifdef JPEG_BRIDGE_PERF_CNT_EN
   localparam logic [1:0] PERF_RESP = 2'b00;
`else
   localparam logic [1:0] PERF_RESP = 2'b10;
`endif

   typedef struct {
      bit          isWr;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
   } rexp_t;

   vec_t        vecs[$];
   logic [1:0]  bExpQ[$];
   rexp_t       rExpQ[$];
   int          checkCount = 0;
   int          errorCount = 0;
   int          startCount = 0;
   int          resReadyCount = 0;

   always #5 clk = ~clk;

   jpeg_axil_stream_bridge dut (
      .s00_axi_aclk    (clk),
      .s00_axi_aresetn (rst_n),
      .s00_axi_awaddr  (awaddr),
      .s00_axi_awvalid (awvalid),
      .s00_axi_awready (awready),
      .s00_axi_wdata   (wdata),
      .s00_axi_wstrb   (wstrb),
      .s00_axi_wvalid  (wvalid),
      .s00_axi_wready  (wready),
      .s00_axi_bresp   (bresp),
      .s00_axi_bvalid  (bvalid),
      .s00_axi_bready  (bready),
      .s00_axi_araddr  (araddr),
      .s00_axi_arvalid (arvalid),
      .s00_axi_arready (arready),
      .s00_axi_rdata   (rdata),
      .s00_axi_rresp   (rresp),
      .s00_axi_rvalid  (rvalid),
      .s00_axi_rready  (rready),
      .pix_tdata       (pix_tdata),
      .pix_tvalid      (pix_tvalid),
      .pix_tready      (pix_tready),
      .res_tdata       (res_tdata),
      .res_tvalid      (res_tvalid),
      .res_tready      (res_tready),
      .core_start      (core_start),
      .core_done       (core_done),
      .jpeg_irq        (jpeg_irq)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Scoreboard: responses are compared at negedge while the handshake is pending.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (core_start) startCount++;
         if (res_tready) resReadyCount++;
         if (bvalid && bready) begin
            if (bExpQ.size() == 0) begin
               checkCount++; errorCount++;
               $display("[TB] FAIL unexpected bresp: got 0x%0h, expected no response", bresp);
            end else begin
               checkOutput("bresp", 32'(bresp), 32'(bExpQ.pop_front()));
            end
         end
         if (rvalid && rready) begin
            if (rExpQ.size() == 0) begin
               checkCount++; errorCount++;
               $display("[TB] FAIL unexpected rvalid: got rdata 0x%08h, expected no response", rdata);
            end else begin
               rexp_t e;
               e = rExpQ.pop_front();
               checkOutput("rdata", rdata, e.data);
               checkOutput("rresp", 32'(rresp), 32'(e.resp));
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sendAwW(input bit doAw, input bit doW, input logic [7:0] addr,
                          input logic [31:0] data, input logic [3:0] strb);
      if (doAw) begin awaddr = addr; awvalid = 1'b1; end
      if (doW)  begin wdata = data; wstrb = strb; wvalid = 1'b1; end
      for (int i = 0; i < 100 && (awvalid || wvalid); i++) begin
         bit awGo, wGo;
         awGo = awvalid && awready;
         wGo  = wvalid && wready;
         tick(1);
         if (awGo) awvalid = 1'b0;
         if (wGo)  wvalid = 1'b0;
      end
      if (awvalid || wvalid) begin
         checkOutput("aw/w handshake timeout", {30'b0, awvalid, wvalid}, 32'h0);
         awvalid = 1'b0;
         wvalid  = 1'b0;
      end
   endtask

   task automatic waitB();
      for (int i = 0; i < 100; i++) begin
         if (bvalid) begin tick(1); return; end
         tick(1);
      end
      checkOutput("bvalid timeout", 32'(bvalid), 32'h1);
   endtask

   task automatic axiWrite(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] expResp, input int lead);
      bExpQ.push_back(expResp);
      if (lead == 0) begin
         sendAwW(1'b1, 1'b1, addr, data, strb);
      end else if (lead > 0) begin
         sendAwW(1'b1, 1'b0, addr, data, strb);
         tick(lead);
         sendAwW(1'b0, 1'b1, addr, data, strb);
      end else begin
         sendAwW(1'b0, 1'b1, addr, data, strb);
         tick(-lead);
         sendAwW(1'b1, 1'b0, addr, data, strb);
      end
      waitB();
   endtask

   task automatic axiRead(input logic [7:0] addr, input logic [31:0] expData, input logic [1:0] expResp);
      rexp_t e;
      e.data = expData;
      e.resp = expResp;
      rExpQ.push_back(e);
      araddr  = addr;
      arvalid = 1'b1;
      for (int i = 0; i < 100 && arvalid; i++) begin
         bit go;
         go = arready;
         tick(1);
         if (go) arvalid = 1'b0;
      end
      if (arvalid) begin
         checkOutput("ar handshake timeout", 32'(arvalid), 32'h0);
         arvalid = 1'b0;
      end
      for (int i = 0; i < 100; i++) begin
         if (rvalid) begin tick(1); return; end
         tick(1);
      end
      checkOutput("rvalid timeout", 32'(rvalid), 32'h1);
   endtask

   task automatic applyStimulus(input vec_t v);
      if (v.isWr) axiWrite(v.addr, v.data, v.strb, v.resp, 0);
      else        axiRead(v.addr, v.rdata, v.resp);
   endtask

   function automatic void addVec(input bit isWr, input logic [7:0] addr, input logic [31:0] data,
                                  input logic [3:0] strb, input logic [1:0] resp, input logic [31:0] rd);
      vec_t v;
      v.isWr = isWr; v.addr = addr; v.data = data; v.strb = strb; v.resp = resp; v.rdata = rd;
      vecs.push_back(v);
   endfunction

   task automatic checkAllIdle(input string tag);
      checkOutput({tag, " awready"}, 32'(awready), 32'h0);
      checkOutput({tag, " wready"}, 32'(wready), 32'h0);
      checkOutput({tag, " arready"}, 32'(arready), 32'h0);
      checkOutput({tag, " bvalid"}, 32'(bvalid), 32'h0);
      checkOutput({tag, " rvalid"}, 32'(rvalid), 32'h0);
      checkOutput({tag, " pix_tvalid"}, 32'(pix_tvalid), 32'h0);
      checkOutput({tag, " pix_tdata"}, pix_tdata, 32'h0);
      checkOutput({tag, " core_start"}, 32'(core_start), 32'h0);
      checkOutput({tag, " jpeg_irq"}, 32'(jpeg_irq), 32'h0);
      checkOutput({tag, " res_tready"}, 32'(res_tready), 32'h0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset state and registered ready release.
      tick(3);
      checkAllIdle("reset");
      rst_n = 1'b1;
      checkOutput("awready before first edge", 32'(awready), 32'h0);
      tick(1);
      checkOutput("awready after release", 32'(awready), 32'h1);
      checkOutput("arready after release", 32'(arready), 32'h1);

      // CSR map vectors.
      addVec(0, 8'h00, 0, 4'h0, 2'b00, 32'h0);
      addVec(0, 8'h04, 0, 4'h0, 2'b00, 32'h0);
      addVec(1, 8'h00, 32'h2, 4'hF, 2'b00, 0);
      addVec(0, 8'h00, 0, 4'h0, 2'b00, 32'h2);
      addVec(1, 8'h04, 32'h0, 4'hF, 2'b10, 0);
      addVec(0, 8'h08, 0, 4'h0, 2'b10, 32'h0);
      addVec(0, 8'h18, 0, 4'h0, 2'b10, 32'h0);
      addVec(1, 8'h1C, 32'h1, 4'hF, 2'b10, 0);
      addVec(1, 8'h00, 32'h0, 4'h0, 2'b00, 0);
      addVec(0, 8'h03, 0, 4'h0, 2'b00, 32'h2);
      addVec(1, 8'h00, 32'h0, 4'hF, 2'b00, 0);
      addVec(0, 8'h00, 0, 4'h0, 2'b00, 32'h0);
      addVec(0, 8'h10, 0, 4'h0, 2'b00, 32'h0);
      addVec(1, 8'h0C, 32'h5, 4'hF, 2'b10, 0);
      addVec(0, 8'h14, 0, 4'h0, PERF_RESP, 32'h0);
      foreach (vecs[i]) applyStimulus(vecs[i]);

      // Fill the FIFO, then a 17th push must stall until one pop.
      for (int i = 0; i < 16; i++) axiWrite(8'h08, 32'hA000_0000 + i, 4'hF, 2'b00, 0);
      axiRead(8'h04, 32'h0000_1000, 2'b00);
      checkOutput("pix_tvalid full", 32'(pix_tvalid), 32'h1);
      checkOutput("pix_tdata head", pix_tdata, 32'hA000_0000);
      bExpQ.push_back(2'b00);
      sendAwW(1'b1, 1'b1, 8'h08, 32'hA000_0010, 4'hF);
      tick(5);
      checkOutput("bvalid stalled on full", 32'(bvalid), 32'h0);
      pix_tready = 1'b1;
      tick(1);
      pix_tready = 1'b0;
      waitB();
      checkOutput("pix_tdata after pop", pix_tdata, 32'hA000_0001);
      axiRead(8'h04, 32'h0000_1000, 2'b00);

      // Partial-strobe pixel write and unmapped read.
      axiWrite(8'h08, 32'h1234_5678, 4'b0111, 2'b10, 0);
      axiRead(8'h18, 32'h0, 2'b10);
      axiRead(8'h04, 32'h0000_1000, 2'b00);

      // Result pops.
      resReadyCount = 0;
      axiRead(8'h0C, 32'h0, 2'b10);
      checkOutput("res_tready when empty", 32'(resReadyCount), 32'h0);
      res_tdata  = 32'hDEAD_BEEF;
      res_tvalid = 1'b1;
      axiRead(8'h04, 32'h0000_1004, 2'b00);
      axiRead(8'h0C, 32'hDEAD_BEEF, 2'b00);
      tick(2);
      res_tvalid = 1'b0;
      checkOutput("res_tready pulse count", 32'(resReadyCount), 32'h1);

      // START with AW three cycles ahead of W, then completion raises the IRQ.
      startCount = 0;
      axiWrite(8'h00, 32'h3, 4'hF, 2'b00, 3);
      tick(2);
      checkOutput("core_start pulses", 32'(startCount), 32'h1);
      axiRead(8'h04, 32'h0000_1001, 2'b00);
      axiRead(8'h00, 32'h2, 2'b00);
      core_done = 1'b1;
      tick(1);
      core_done = 1'b0;
      checkOutput("jpeg_irq latency", 32'(jpeg_irq), 32'h0);
      tick(1);
      checkOutput("jpeg_irq set", 32'(jpeg_irq), 32'h1);
      axiRead(8'h04, 32'h0000_1002, 2'b00);
      axiRead(8'h10, 32'h1, 2'b00);

      // W1C executing in the same cycle as core_done: set wins.
      bExpQ.push_back(2'b00);
      sendAwW(1'b1, 1'b1, 8'h10, 32'h1, 4'hF);
      core_done = 1'b1;
      tick(1);
      core_done = 1'b0;
      waitB();
      axiRead(8'h10, 32'h1, 2'b00);
      checkOutput("jpeg_irq after race", 32'(jpeg_irq), 32'h1);
      axiWrite(8'h10, 32'h1, 4'hF, 2'b00, -2);
      axiRead(8'h10, 32'h0, 2'b00);
      checkOutput("jpeg_irq cleared", 32'(jpeg_irq), 32'h0);

      // Drain to five entries, hold a write, then reset mid-transaction.
      pix_tready = 1'b1;
      tick(11);
      pix_tready = 1'b0;
      axiRead(8'h04, 32'h0000_0502, 2'b00);
      sendAwW(1'b1, 1'b0, 8'h00, 32'h0, 4'hF);
      rst_n = 1'b0;
      #1;
      checkAllIdle("mid reset");
      tick(2);
      rst_n = 1'b1;
      tick(2);
      checkOutput("level after reset", 32'(pix_tvalid), 32'h0);
      checkOutput("bvalid after reset", 32'(bvalid), 32'h0);
      axiRead(8'h04, 32'h0, 2'b00);
      axiRead(8'h00, 32'h0, 2'b00);
      axiRead(8'h14, 32'h0, PERF_RESP);

      tick(3);
      checkOutput("scoreboard drained", 32'(bExpQ.size() + rExpQ.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/jpeg_axil_stream_bridge.md
Name: jpeg_axil_stream_bridge

Overview:
- Parametrised AXI4-Lite slave front-end for the JPEG compression pipeline.
- Decodes a CSR map, packs CPU writes into a buffered pixel stream and pops the compressed result stream on CPU reads.
- Tracks core busy/done and raises a maskable interrupt.
- Sits between the PS interconnect and the JPEG core. Independent AW/W acceptance, byte strobes, error responses and backpressure are included.

Parameters:
DATA_WIDTH, 32, AXI data width and pixel/result stream width (multiple of 8).
ADDR_WIDTH, 8, AXI address width (>=5).
PIX_FIFO_DEPTH, 16, pixel FIFO entries (power of 2, >=2).

Ports:
s00_axi_aclk  in  1  clock
s00_axi_aresetn  in  1  asynchronous active-low reset
s00_axi_awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  write address channel
s00_axi_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
s00_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response
s00_axi_araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  read address
s00_axi_rdata/rresp/rvalid/rready  out/out/out/in  DATA_WIDTH/2/1/1  read data
pix_tdata/pix_tvalid/pix_tready  out/out/in  DATA_WIDTH/1/1  pixel stream to core
res_tdata/res_tvalid/res_tready  in/in/out  DATA_WIDTH/1/1  result stream from core
core_start  out  1  one-cycle start pulse
core_done  in  1  one-cycle completion pulse
jpeg_irq  out  1  level interrupt

Behaviour:
- Reset: all outputs 0, FIFO emptied, all CSRs 0. Assertion mid-transaction discards any pending AXI transfer and all FIFO contents. Ready outputs are registered and rise the first cycle after release.
- Write path:
  - awready=1 while no address is held and bvalid=0; wready likewise for data. AW and W may arrive in either order or in the same cycle.
  - With both held, the write executes at the next edge; bvalid rises that cycle and holds until bready.
  - If the PIX_DATA target FIFO is full, execution and bvalid stall until the FIFO has space.
  - One outstanding write only.
- Read path:
  - arready=1 while no read is pending and rvalid=0. rvalid follows the handshake by 1 cycle and holds with stable rdata until rready.
  - One outstanding read only.
  - A read and a write in the same cycle: the read samples the pre-write value.
- Register map (word offsets, addr[1:0] ignored):
  - 0x00 CTRL: bit0 START (W, self-clearing; pulses core_start the cycle after the write, ignored if busy=1), bit1 IRQ_EN (RW).
  - 0x04 STATUS, RO: bit0 busy, bit1 done, bit2 res_tvalid, [15:8] FIFO level.
  - 0x08 PIX_DATA, WO: pushes wdata; all wstrb bits must be 1, otherwise SLVERR and no push.
  - 0x0C RESULT, RO: if res_tvalid, returns res_tdata and pulses res_tready for exactly 1 cycle; if empty, returns rdata=0, SLVERR, no pulse.
  - 0x10 IRQ_STAT: bit0 done-sticky, write-1-to-clear.
- wstrb merges bytes on CTRL and IRQ_STAT.
- Unmapped offset, write to an RO register, or read of a WO register: SLVERR (2'b10), no side effect, rdata=0. All other accesses return OKAY.
- Status tracking:
  - busy sets with core_start and clears on core_done. done and IRQ_STAT[0] set on core_done.
  - core_done and a W1C in the same cycle: set wins. START write clears done.
- jpeg_irq is registered: IRQ_EN & IRQ_STAT[0], 1-cycle latency.
- FIFO: pix_tvalid = !empty. Pop on pix_tvalid & pix_tready. A push when full is refused even if a pop occurs the same cycle. Level width is clog2(PIX_FIFO_DEPTH)+1.

Optional Feature:
- Macro JPEG_BRIDGE_PERF_CNT_EN.
- Defined: adds 0x14 PERF, RO, a 32-bit count of cycles with busy=1. It clears on START, saturates at 0xFFFFFFFF and holds after done.
- Undefined: 0x14 is unmapped and returns SLVERR; no counter logic is present.

Decomposition:
- Package jpeg_axil_pkg: register offsets, RESP_OKAY/RESP_SLVERR constants, CTRL/STATUS bit indices.
- Sub-module jpeg_pix_fifo: synchronous FIFO parametrised by width and depth, with level output.

Test Plan:
- AW presented 3 cycles before W (CTRL=0x3) -> single bvalid with OKAY, core_start pulses once, IRQ_EN=1. Then core_done -> jpeg_irq=1 one cycle later.
- 17 PIX_DATA writes with pix_tready=0 (DEPTH 16) -> first 16 complete with OKAY and STATUS[15:8]=16. 17th bvalid is withheld until one pix_tready cycle, then OKAY.
- RESULT read with res_tvalid=0 -> rresp=2'b10, rdata=0, no res_tready. With res_tvalid=1 and data 0xDEADBEEF -> rdata=0xDEADBEEF, res_tready high for 1 cycle.
- Write 0x1 to IRQ_STAT in the same cycle as core_done -> IRQ_STAT[0] stays 1. A later W1C clears it and jpeg_irq drops.
- Read 0x18 and write PIX_DATA with wstrb=4'b0111 -> both SLVERR, FIFO level unchanged.
- Reset asserted with a write held and 5 FIFO entries -> all outputs 0, level 0 after release. PERF reads 0 (macro on) or SLVERR (macro off).
